// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared width defaults and types for the clk_gen phase-accumulator clock generator
`timescale 1ns/1ps
package clk_gen_pkg;

    localparam int DEFAULT_SEL_WIDTH = 8;

    // One extra bit so that the increment freq_sel+1 always fits.
    typedef logic [DEFAULT_SEL_WIDTH:0] acc_t;

endpackage

// File: rtl/clk_gen_phase_acc.sv
// rtl/clk_gen_phase_acc.sv - free-running modulo-2^WIDTH phase accumulator with hold and synchronous clear
`timescale 1ns/1ps
module clk_gen_phase_acc #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             halt,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] acc
);

    // Clear beats halt so a stuck generator can always be re-phased.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc <= '0;
        end else if (!halt) begin
            acc <= acc + inc;
        end
    end

endmodule

// File: rtl/clk_gen.sv
// rtl/clk_gen.sv - DDS-style fractional clock generator, clk_o = MSB of a (SEL_WIDTH+1)-bit phase accumulator
`timescale 1ns/1ps
module clk_gen
    import clk_gen_pkg::*;
#(
    parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [SEL_WIDTH-1:0] freq_sel,
    input  logic                 halt,
    output logic                 clk_o
);

    logic [SEL_WIDTH:0] inc;
    logic [SEL_WIDTH:0] acc;

    // Range 1..2^SEL_WIDTH: fits the accumulator width without overflow.
    assign inc = {1'b0, freq_sel} + {{SEL_WIDTH{1'b0}}, 1'b1};

    clk_gen_phase_acc #(
        .WIDTH (SEL_WIDTH + 1)
    ) u_acc (
        .clk  (clk_i),
        .clr  (rst_i),
        .halt (halt),
        .inc  (inc),
        .acc  (acc)
    );

    // Tapped straight from the register so clk_o carries no combinational glitches.
    assign clk_o = acc[SEL_WIDTH];

endmodule

// File: tb/tb_clk_gen.sv
// tb/tb_clk_gen.sv - directed self-checking bench for clk_gen
`timescale 1ns/1ps
module tb_clk_gen;
    import clk_gen_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] freq_sel = 8'd0;
    logic       halt = 1'b0;
    logic       clk_o;

    int checks = 0;
    int failures = 0;
    int n;
    int n2;
    int total;
    logic exp_lvl;
    logic [7:0] pat;
    acc_t acc_obs;

    clk_gen #(.SEL_WIDTH(8)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .freq_sel (freq_sel),
        .halt     (halt),
        .clk_o    (clk_o)
    );

    always #0.833 clk_i = ~clk_i;

    assign acc_obs = dut.u_acc.acc;

    task automatic step();
        @(posedge clk_i);
        #0.2;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Steps until clk_o reaches lvl; cnt = -1 if the budget expires.
    task automatic wait_level(input logic lvl, input int limit, output int cnt);
        cnt = 0;
        while (clk_o !== lvl) begin
            if (cnt >= limit) begin
                cnt = -1;
                return;
            end
            step();
            cnt++;
        end
    endtask

    // Cycles from the current low phase to the next falling edge.
    task automatic wait_fall(input int limit, output int cnt);
        int a;
        int b;
        wait_level(1'b1, limit, a);
        wait_level(1'b0, limit, b);
        cnt = (a < 0 || b < 0) ? -1 : a + b;
    endtask

    initial begin
        // Reset and slowest setting
        rst_i = 1'b1; freq_sel = 8'd0; halt = 1'b0;
        step();
        check("reset_clk_o", int'(clk_o), 0);
        check("reset_acc", int'(acc_obs), 0);
        rst_i = 1'b0;
        wait_level(1'b1, 1000, n);
        check("sel0_first_rise", n, 256);
        wait_level(1'b0, 1000, n2);
        check("sel0_first_fall", (n2 < 0) ? -1 : n + n2, 512);
        wait_level(1'b1, 1000, n);
        check("sel0_period", (n < 0) ? -1 : n2 + n, 512);

        // Maximum select toggles every cycle, starting from clk_o high
        freq_sel = 8'd255;
        exp_lvl = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_lvl = ~exp_lvl;
            check("sel255_toggle", int'(clk_o), int'(exp_lvl));
        end

        // Power-of-two increment: 2 high / 2 low
        rst_i = 1'b1; freq_sel = 8'd127;
        step();
        rst_i = 1'b0;
        pat = 8'b01100110;
        for (int i = 7; i >= 0; i--) begin
            step();
            check("sel127_pattern", int'(clk_o), int'(pat[i]));
        end
        step();
        step();
        check("sel127_pre_halt", int'(clk_o), 1);

        // Halt freezes phase, then resumes without re-phasing
        halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_clk_o", int'(clk_o), 1);
            check("halt_acc", int'(acc_obs), 256);
        end
        halt = 1'b0;
        pat = 8'b00100110;
        for (int i = 5; i >= 0; i--) begin
            step();
            check("halt_resume", int'(clk_o), int'(pat[i]));
        end
        step();
        step();
        check("pre_rst_halt", int'(clk_o), 1);
        halt = 1'b1; rst_i = 1'b1; freq_sel = 8'd200;
        step();
        check("rst_over_halt_clk_o", int'(clk_o), 0);
        check("rst_over_halt_acc", int'(acc_obs), 0);
        halt = 1'b0;

        // Non-power-of-two increment: periods of 170/171 cycles
        freq_sel = 8'd2;
        step();
        rst_i = 1'b0;
        wait_level(1'b1, 1000, n);
        check("sel2_first_rise", n, 86);
        wait_level(1'b0, 1000, n2);
        check("sel2_first_fall", (n2 < 0) ? -1 : n + n2, 171);
        total = 0;
        for (int i = 0; i < 4; i++) begin
            wait_fall(1000, n);
            check_range("sel2_period", n, 170, 171);
            total += n;
        end
        check("sel2_four_periods", total, 683);

        // Sweep: phase-continuous select changes; s+1 periods should span ~512 cycles
        for (int s = 0; s < 256; s++) begin
            freq_sel = 8'(s);
            if (s < 4 || (s % 16) == 15 || s >= 252) begin
                wait_fall(1100, n);
                total = (n < 0) ? -100000 : 0;
                for (int p = 0; p <= s; p++) begin
                    wait_fall(1100, n);
                    total += (n < 0) ? -100000 : n;
                end
                check_range($sformatf("sweep_sel%0d_cycles", s), total, 488, 538);
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
